// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command decoder.
// Optional build macro honoured by the decoder: UART_CMD_CHECKSUM_EN.
package uart_cmd_pkg;

  // Decoder states. S_CHK exists in the encoding in every build but is only
  // reachable when the checksum byte is part of the frame.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_OP   = 3'd1,
    S_ADDR = 3'd2,
    S_DATA = 3'd3,
    S_CHK  = 3'd4,
    S_HOLD = 3'd5
  } state_t;

  localparam logic [7:0] OP_WRITE          = 8'h57;
  localparam logic [7:0] OP_READ           = 8'h52;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // True for the two opcodes the decoder understands.
  function automatic logic is_valid_op(input logic [7:0] b);
    return (b == OP_WRITE) || (b == OP_READ);
  endfunction

  // Expected CHK byte. The OP byte is not stored; it is rebuilt from the
  // latched write flag because only two opcodes can reach this point.
  function automatic logic [7:0] frame_chk(input logic       wr,
                                           input logic [7:0] addr,
                                           input logic [7:0] data);
    return (wr ? OP_WRITE : OP_READ) ^ addr ^ data;
  endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte timeout: loadable down-counter. Reload wins over everything;
// while not running the counter sits at zero. Expiry is reported in the
// TIMEOUT_CYCLES-th running cycle after the last reload.
module uart_cmd_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 208320
) (
  input  logic clk,
  input  logic rst,
  input  logic reload,
  input  logic run,
  output logic expired
);

  localparam int unsigned     CW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]   LOAD = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]   ONE  = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: reload on a byte, clear when idle, otherwise count down.
  always_comb begin
    cnt_d = cnt_q;
    if (reload) begin
      cnt_d = LOAD;
    end else if (!run) begin
      cnt_d = '0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - ONE;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired = run && !reload && (cnt_q <= ONE);

endmodule

// File: rtl/uart_cmd_decoder.sv
// UART byte-stream command decoder: hunts SYNC, assembles OP/ADDR/DATA[/CHK],
// presents one register command on a valid/ready port and reports framing,
// checksum, timeout and overrun errors as registered one-cycle pulses.
// Build macro: UART_CMD_CHECKSUM_EN adds the CHK byte (5-byte frames);
// without it frames are 4 bytes and err_checksum is constant 0.
//
// Handshake: cmd_valid is high exactly while in HOLD; the command fields do
// not change while cmd_valid is high; a transfer happens on any cycle with
// cmd_valid && cmd_ready, and cmd_valid drops on the following cycle.
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int unsigned CLK_FREQ      = 50000000,
  parameter int unsigned BAUD_RATE     = 9600,
  parameter int unsigned TIMEOUT_BYTES = 4,
  parameter logic [7:0]  SYNC_BYTE     = SYNC_BYTE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic       cmd_write,
  output logic [7:0] cmd_addr,
  output logic [7:0] cmd_wdata,
  output logic       err_opcode,
  output logic       err_checksum,
  output logic       err_timeout,
  output logic       err_overrun
);

  // One byte time is 10 bit times (start + 8 data + stop).
  localparam int unsigned TIMEOUT_CYCLES = TIMEOUT_BYTES * 10 * (CLK_FREQ / BAUD_RATE);

  state_t     state_q, state_d;
  logic       cmd_write_q, cmd_write_d;
  logic [7:0] cmd_addr_q, cmd_addr_d;
  logic [7:0] cmd_wdata_q, cmd_wdata_d;
  logic       err_opcode_q, err_opcode_d;
  logic       err_timeout_q, err_timeout_d;
  logic       err_overrun_q, err_overrun_d;
`ifdef UART_CMD_CHECKSUM_EN
  logic       err_checksum_q, err_checksum_d;
`endif

  logic to_run, to_expired;

  // The timeout only matters while a frame is partially assembled.
  assign to_run = (state_q == S_OP) || (state_q == S_ADDR) ||
                  (state_q == S_DATA) || (state_q == S_CHK);

  uart_cmd_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .reload (in_valid),
    .run    (to_run),
    .expired(to_expired)
  );

  // Next-state, field capture and error-pulse decode.
  always_comb begin
    state_d       = state_q;
    cmd_write_d   = cmd_write_q;
    cmd_addr_d    = cmd_addr_q;
    cmd_wdata_d   = cmd_wdata_q;
    err_opcode_d  = 1'b0;
    err_timeout_d = 1'b0;
    err_overrun_d = 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
    err_checksum_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid && (in_data == SYNC_BYTE)) state_d = S_OP;
      end
      S_OP: begin
        if (in_valid) begin
          if (is_valid_op(in_data)) begin
            cmd_write_d = (in_data == OP_WRITE);
            state_d     = S_ADDR;
          end else begin
            err_opcode_d = 1'b1;
            state_d      = S_IDLE;
          end
        end else if (to_expired) begin
          err_timeout_d = 1'b1;
          state_d       = S_IDLE;
        end
      end
      S_ADDR: begin
        if (in_valid) begin
          cmd_addr_d = in_data;
          state_d    = S_DATA;
        end else if (to_expired) begin
          err_timeout_d = 1'b1;
          state_d       = S_IDLE;
        end
      end
      S_DATA: begin
        if (in_valid) begin
          cmd_wdata_d = in_data;
`ifdef UART_CMD_CHECKSUM_EN
          state_d     = S_CHK;
`else
          state_d     = S_HOLD;
`endif
        end else if (to_expired) begin
          err_timeout_d = 1'b1;
          state_d       = S_IDLE;
        end
      end
`ifdef UART_CMD_CHECKSUM_EN
      S_CHK: begin
        if (in_valid) begin
          if (in_data == frame_chk(cmd_write_q, cmd_addr_q, cmd_wdata_q)) begin
            state_d = S_HOLD;
          end else begin
            err_checksum_d = 1'b1;
            state_d        = S_IDLE;
          end
        end else if (to_expired) begin
          err_timeout_d = 1'b1;
          state_d       = S_IDLE;
        end
      end
`endif
      S_HOLD: begin
        // A byte arriving on the transfer cycle is judged by IDLE rules.
        if (cmd_ready) begin
          if (in_valid && (in_data == SYNC_BYTE)) state_d = S_OP;
          else                                    state_d = S_IDLE;
        end else if (in_valid) begin
          err_overrun_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, field and error-pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cmd_write_q   <= 1'b0;
      cmd_addr_q    <= 8'h00;
      cmd_wdata_q   <= 8'h00;
      err_opcode_q  <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_write_q   <= cmd_write_d;
      cmd_addr_q    <= cmd_addr_d;
      cmd_wdata_q   <= cmd_wdata_d;
      err_opcode_q  <= err_opcode_d;
      err_timeout_q <= err_timeout_d;
      err_overrun_q <= err_overrun_d;
    end
  end

`ifdef UART_CMD_CHECKSUM_EN
  // Checksum error pulse register.
  always_ff @(posedge clk) begin
    if (rst) err_checksum_q <= 1'b0;
    else     err_checksum_q <= err_checksum_d;
  end
  assign err_checksum = err_checksum_q;
`else
  assign err_checksum = 1'b0;
`endif

  assign cmd_valid   = (state_q == S_HOLD);
  assign cmd_write   = cmd_write_q;
  assign cmd_addr    = cmd_addr_q;
  assign cmd_wdata   = cmd_wdata_q;
  assign err_opcode  = err_opcode_q;
  assign err_timeout = err_timeout_q;
  assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Bench for uart_cmd_decoder: directed cases followed by a randomized byte
// stream, all checked against a frame-level reference model and a command
// scoreboard. Honours UART_CMD_CHECKSUM_EN for the expected frame length.
module tb_uart_cmd_decoder;

  // Small clock ratio so the inter-byte timeout is 200 cycles.
  localparam int unsigned CLK_FREQ  = 1000;
  localparam int unsigned BAUD_RATE = 100;
  localparam int unsigned TO_BYTES  = 2;
  localparam int          TC        = TO_BYTES * 10 * (CLK_FREQ / BAUD_RATE);
  localparam logic [7:0]  SYNC      = 8'hA5;
`ifdef UART_CMD_CHECKSUM_EN
  localparam int          FRAME_LEN = 5;
`else
  localparam int          FRAME_LEN = 4;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       err_opcode;
  logic       err_checksum;
  logic       err_timeout;
  logic       err_overrun;

  uart_cmd_decoder #(
    .CLK_FREQ     (CLK_FREQ),
    .BAUD_RATE    (BAUD_RATE),
    .TIMEOUT_BYTES(TO_BYTES),
    .SYNC_BYTE    (SYNC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .err_opcode  (err_opcode),
    .err_checksum(err_checksum),
    .err_timeout (err_timeout),
    .err_overrun (err_overrun)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // exp_q holds {write, addr, data} of each command the decoder must issue.
  logic [16:0] exp_q[$];
  logic [7:0]  fbuf[$];
  int exp_opc = 0, exp_chk = 0, exp_to = 0, exp_ovr = 0;
  int obs_opc = 0, obs_chk = 0, obs_to = 0, obs_ovr = 0;

  // Frame-level parse of the byte stream: collect bytes starting at SYNC,
  // judge the opcode at byte 2 and the whole frame at FRAME_LEN bytes.
  function automatic void model_byte(input logic [7:0] b);
    logic ok;
    if (fbuf.size() == 0) begin
      if (b == SYNC) fbuf.push_back(b);
      return;
    end
    fbuf.push_back(b);
    if (fbuf.size() == 2 && b != 8'h57 && b != 8'h52) begin
      exp_opc++;
      fbuf.delete();
      return;
    end
    if (fbuf.size() == FRAME_LEN) begin
      ok = 1'b1;
`ifdef UART_CMD_CHECKSUM_EN
      ok = ((fbuf[1] ^ fbuf[2] ^ fbuf[3]) == fbuf[4]);
`endif
      if (ok) exp_q.push_back({fbuf[1] == 8'h57, fbuf[2], fbuf[3]});
      else    exp_chk++;
      fbuf.delete();
    end
  endfunction

  // ---------------- monitor ----------------
  logic [3:0]  errs, prev_errs;
  logic        prev_valid, prev_ready;
  logic [16:0] prev_cmd, got_cmd;

  // Sample on the falling edge: transfers, field stability, error pulses.
  always @(negedge clk) begin
    if (rst) begin
      prev_errs  = '0;
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      got_cmd = {cmd_write, cmd_addr, cmd_wdata};
      if (prev_valid && !prev_ready && cmd_valid)
        check_eq("held_cmd_stable", got_cmd, prev_cmd);
      if (cmd_valid && cmd_ready) begin
        check_eq("cmd_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check_eq("cmd_fields", got_cmd, exp_q.pop_front());
      end
      errs = {err_opcode, err_checksum, err_timeout, err_overrun};
      if (errs != 0) begin
        check_eq("err_onehot", $countones(errs), 1);
        check_eq("err_pulse_width", errs & prev_errs, 0);
      end
      if (err_opcode)   obs_opc++;
      if (err_checksum) obs_chk++;
      if (err_timeout)  obs_to++;
      if (err_overrun)  obs_ovr++;
      prev_errs  = errs;
      prev_valid = cmd_valid;
      prev_ready = cmd_ready;
      prev_cmd   = got_cmd;
    end
  end

  // ---------------- drivers ----------------
  // All drivers start and end #1 after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    model_byte(b);
    drive(b);
    idle(gap);
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [7:0] addr,
                            input logic [7:0] data, input logic [7:0] chk,
                            input int gap);
    send_byte(SYNC, gap);
    send_byte(op, gap);
    send_byte(addr, gap);
    send_byte(data, gap);
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(chk, gap);
`else
    if (chk == 8'h00) idle(0);
`endif
  endtask

  task automatic check_counts(input string tag);
    check_eq({tag, "_opcode"},   obs_opc, exp_opc);
    check_eq({tag, "_checksum"}, obs_chk, exp_chk);
    check_eq({tag, "_timeout"},  obs_to,  exp_to);
    check_eq({tag, "_overrun"},  obs_ovr, exp_ovr);
    check_eq({tag, "_drained"},  exp_q.size(), 0);
  endtask

  task automatic check_quiet_outputs(input string tag);
    check_eq({tag, "_outs"},
             {cmd_valid, cmd_write, cmd_addr, cmd_wdata,
              err_opcode, err_checksum, err_timeout, err_overrun}, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] op, a, d, b;
    int kind;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    cmd_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet_outputs("reset");
    rst = 1'b0;
    idle(2);
    check_quiet_outputs("after_reset");

    // Valid write, held with cmd_ready low, then an overrun byte.
    send_frame(8'h57, 8'h10, 8'h3C, 8'h7B, 0);
    idle(4);
    check_eq("hold_valid", cmd_valid, 1);
    check_eq("hold_fields", {cmd_write, cmd_addr, cmd_wdata}, {1'b1, 8'h10, 8'h3C});
    drive(8'h33);
    exp_ovr++;
    idle(3);
    check_eq("overrun_still_valid", cmd_valid, 1);
    check_eq("overrun_fields", {cmd_write, cmd_addr, cmd_wdata}, {1'b1, 8'h10, 8'h3C});
    check_eq("overrun_pulse", obs_ovr, exp_ovr);
    // Ready coincides with the SYNC of the next frame.
    cmd_ready = 1'b1;
    send_frame(8'h57, 8'h01, 8'h02, 8'h54, 0);
    idle(3);
    check_counts("write_overrun");

    // Bad checksum then a good read.
    send_frame(8'h52, 8'h20, 8'h00, 8'h00, 0);
    idle(3);
    send_frame(8'h52, 8'h20, 8'h00, 8'h72, 1);
    idle(3);
    check_counts("checksum");

    // Bad opcode, then a good frame.
    send_byte(SYNC, 0);
    send_byte(8'h41, 0);
    send_frame(8'h57, 8'h01, 8'h02, 8'h54, 0);
    idle(3);
    check_counts("opcode");

    // Timeout: no pulse well inside the window, one pulse after it.
    send_byte(SYNC, 0);
    send_byte(8'h57, 0);
    send_byte(8'h10, 0);
    idle(TC - 20);
    check_eq("timeout_early", obs_to, exp_to);
    idle(40);
    exp_to++;
    fbuf.delete();
    check_eq("timeout_fired", obs_to, exp_to);
    check_eq("timeout_idle", cmd_valid, 0);
    send_frame(8'h52, 8'h7E, 8'hA5, 8'h52 ^ 8'h7E ^ 8'hA5, 2);
    idle(3);
    check_counts("timeout");

    // Reset mid-frame abandons it silently.
    send_byte(SYNC, 0);
    send_byte(8'h57, 0);
    rst = 1'b1;
    fbuf.delete();
    @(posedge clk);
    #1;
    check_quiet_outputs("mid_reset");
    rst = 1'b0;
    idle(3);
    check_quiet_outputs("post_mid_reset");
    send_frame(8'h57, 8'hC3, 8'h5A, 8'h57 ^ 8'hC3 ^ 8'h5A, 0);
    idle(3);
    check_counts("reset_mid");

    // Randomized stream with cmd_ready held high.
    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 5);
      op   = ($urandom_range(0, 1) != 0) ? 8'h57 : 8'h52;
      a    = 8'($urandom);
      d    = 8'($urandom);
      case (kind)
        3: send_frame(op, a, d, op ^ a ^ d ^ 8'($urandom_range(1, 255)), $urandom_range(0, 3));
        4: begin
          do b = 8'($urandom); while (b == 8'h57 || b == 8'h52);
          send_byte(SYNC, $urandom_range(0, 3));
          send_byte(b, $urandom_range(0, 3));
        end
        5: begin
          do b = 8'($urandom); while (b == SYNC);
          send_byte(b, $urandom_range(0, 3));
        end
        default: send_frame(op, a, d, op ^ a ^ d, $urandom_range(0, 3));
      endcase
    end
    idle(5);
    check_counts("random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cmd_decoder.md
# uart_cmd_decoder

Byte-stream command decoder sitting directly downstream of the UART receiver. It consumes received bytes (`in_data`/`in_valid`) and hunts for a sync byte. It assembles fixed-length frames (SYNC, OP, ADDR, DATA, CHK), validates opcode and checksum, and presents one decoded register command on a valid/ready port to the register-file side. It also flags framing errors, inter-byte timeouts and overruns as single-cycle pulses.

## Interface
- `CLK_FREQ`, default 50000000: clock frequency in Hz.
- `BAUD_RATE`, default 9600: line baud rate; sets the timeout scale.
- `TIMEOUT_BYTES`, default 4: number of idle byte-times (10 bit-times each) allowed between bytes of one frame.
- `SYNC_BYTE`, default 8'hA5: frame start marker.
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `in_data`  in  8  received byte from the UART receiver.
- `in_valid`  in  1  one-cycle pulse; `in_data` is valid this cycle.
- `cmd_valid`  out  1  decoded command held for the consumer.
- `cmd_ready`  in  1  consumer accepts the command.
- `cmd_write`  out  1  1 = write (OP 8'h57), 0 = read (OP 8'h52).
- `cmd_addr`  out  8  register address.
- `cmd_wdata`  out  8  write data; for a read, the received DATA byte is passed through unchanged.
- `err_opcode`  out  1  pulse: OP byte was not 8'h57 or 8'h52.
- `err_checksum`  out  1  pulse: CHK byte mismatch.
- `err_timeout`  out  1  pulse: frame abandoned on inter-byte timeout.
- `err_overrun`  out  1  pulse: byte dropped while a command was held.

## Operation
- States: IDLE, OP, ADDR, DATA, CHK, HOLD.
- **IDLE:**
  - `in_valid` with `in_data==SYNC_BYTE` -> OP.
  - Any other byte is discarded silently.
- **OP:**
  - 8'h57 or 8'h52 -> latch `cmd_write`, go to ADDR.
  - Any other value -> `err_opcode` pulse, go to IDLE. The offending byte is not re-examined as a sync byte.
- **ADDR:** latch `cmd_addr` -> DATA.
- **DATA:** latch `cmd_wdata` -> CHK.
- **CHK:**
  - `in_data == OP^ADDR^DATA` -> HOLD.
  - Mismatch -> `err_checksum` pulse, go to IDLE.
- **HOLD:**
  - `cmd_valid=1`; `cmd_write`, `cmd_addr` and `cmd_wdata` stay stable until transfer.
  - Transfer occurs on `cmd_valid && cmd_ready`, then the block returns to IDLE.
- **SYNC_BYTE mid-frame** (ADDR, DATA or CHK) is treated as ordinary data. There is no resync.
- **Timeout:**
  - The counter reloads on every `in_valid`.
  - It only runs in OP, ADDR, DATA and CHK.
  - Expiry after TIMEOUT_CYCLES = TIMEOUT_BYTES*10*(CLK_FREQ/BAUD_RATE) cycles -> `err_timeout` pulse, go to IDLE.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- **Overrun:**
  - `in_valid` in HOLD without `cmd_ready` -> byte dropped, `err_overrun` pulse.
  - If `cmd_ready` is high in the same cycle, the transfer completes and the byte is processed with IDLE rules. A SYNC byte then goes straight to OP.

## Timing
- **Reset values:**
  - All outputs 0; state IDLE; timeout counter cleared.
  - Reset mid-frame or in HOLD abandons the frame with no error pulse.
- **Latency:** `cmd_valid` rises 1 cycle after the `in_valid` of the CHK byte. All state updates are registered.
- **Handshake:**
  - `cmd_ready` may be high before `cmd_valid`; transfer then takes one cycle.
  - `cmd_valid` falls the cycle after transfer.
- **Error pulses:**
  - Each error pulse is exactly 1 cycle wide, registered, and asserted the cycle after the triggering event.
  - At most one error pulse is asserted in any cycle.
- **Back-to-back:** consecutive frames are accepted with no gap when `cmd_ready` is held high.

## Configuration
- `UART_CMD_CHECKSUM_EN`:
  - **Defined:** frames are 5 bytes and the CHK state is used as above.
  - **Undefined:** frames are 4 bytes and the CHK state is not built. DATA goes directly to HOLD, and `err_checksum` is tied to 0.

## Structure
- Shared package `uart_cmd_pkg` holds:
  - the state enum;
  - opcode constants `OP_WRITE=8'h57` and `OP_READ=8'h52`;
  - the default `SYNC_BYTE`.
- One sub-module, `uart_cmd_timeout`: a loadable down-counter with inputs `reload` and `run`, output `expired`, parameterised by TIMEOUT_CYCLES.
- The FSM, field registers and checksum XOR stay in the top level.

## Test plan
- **Valid write:** A5 57 10 3C 7B -> `cmd_valid` with `cmd_write=1`, `cmd_addr=8'h10`, `cmd_wdata=8'h3C`; held until `cmd_ready`; no error pulses.
- **Bad checksum:** A5 52 20 00 00 -> `err_checksum` pulse, no `cmd_valid`. A following A5 52 20 00 72 then decodes as a read of 8'h20.
- **Bad opcode:** A5 41 then A5 57 01 02 54 -> `err_opcode` once, then a write of 8'h02 to addr 8'h01.
- **Timeout:** A5 57 10, then silence for more than TIMEOUT_CYCLES -> `err_timeout` pulse and return to IDLE. A later full frame decodes normally.
- **Overrun and simultaneous byte:**
  - With `cmd_ready=0` in HOLD, byte 8'h33 -> `err_overrun` pulse, command unchanged.
  - With `cmd_ready=1` coincident with an A5 byte -> transfer completes, and the next four bytes decode as a new frame.
- **Reset mid-frame:** `rst` pulse after A5 57 -> all outputs 0, no error pulse. A following frame decodes normally.
- **Build check:** repeat the valid-write case with `UART_CMD_CHECKSUM_EN` undefined, sending A5 57 10 3C -> command issued, `err_checksum` never asserts.
